// File: rtl/matrix_stream_writer_if.sv
// Element stream in, storage write port out; slave = the writer, master = producer/storage side.
interface matrix_stream_writer_if #(
  parameter int DATA_W = 32,
  parameter int DIM_W  = 8
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;
  logic              mem_write;
  logic [DIM_W-1:0]  mem_m_addr;
  logic [DIM_W-1:0]  mem_n_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DIM_W-1:0]  mem_m_dim;
  logic [DIM_W-1:0]  mem_n_dim;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, mem_write, mem_m_addr, mem_n_addr, mem_data, mem_m_dim, mem_n_dim
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, mem_write, mem_m_addr, mem_n_addr, mem_data, mem_m_dim, mem_n_dim
  );
endinterface

// File: rtl/matrix_stream_writer.sv
// Loads an M x N matrix from a valid/ready stream into storage, one registered write per accepted beat
// (1-cycle latency, stalls cleanly on s_valid low); MATRIX_WR_TRANSPOSE_EN adds a column-major walk via transpose_in.
module matrix_stream_writer #(
  parameter int DATA_W  = 32,
  parameter int DIM_W   = 8,
  parameter int MAX_DIM = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIM_W-1:0] m_dim,
  input  logic [DIM_W-1:0] n_dim,
`ifdef MATRIX_WR_TRANSPOSE_EN
  input  logic             transpose_in,
`endif
  matrix_stream_writer_if.slave io,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [0:0] {IDLE, LOAD} state_t;

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  row_q, row_d, col_q, col_d;
  logic [DIM_W-1:0]  m_dim_q, m_dim_d, n_dim_q, n_dim_d;
  logic [DIM_W-1:0]  wr_m_q, wr_m_d, wr_n_q, wr_n_d;
  logic [DATA_W-1:0] wr_dat_q, wr_dat_d;
  logic              wr_q, wr_d, done_q, done_d, err_q, err_d;
  logic              tr_q, tr_d;

  logic tr_start;
  logic dims_ok;
  logic row_last, col_last;

`ifdef MATRIX_WR_TRANSPOSE_EN
  assign tr_start = transpose_in;
`else
  assign tr_start = 1'b0;
`endif

  assign dims_ok  = (m_dim != '0) && (n_dim != '0) &&
                    (int'(m_dim) <= MAX_DIM) && (int'(n_dim) <= MAX_DIM);
  assign row_last = (row_q == (m_dim_q - DIM_W'(1)));
  assign col_last = (col_q == (n_dim_q - DIM_W'(1)));

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    m_dim_d  = m_dim_q;
    n_dim_d  = n_dim_q;
    wr_m_d   = wr_m_q;
    wr_n_d   = wr_n_q;
    wr_dat_d = wr_dat_q;
    tr_d     = tr_q;
    wr_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (dims_ok) begin
            m_dim_d = m_dim;
            n_dim_d = n_dim;
            row_d   = '0;
            col_d   = '0;
            tr_d    = tr_start;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (io.s_valid) begin
          wr_d     = 1'b1;
          wr_m_d   = row_q;
          wr_n_d   = col_q;
          wr_dat_d = io.s_data;
          if (row_last && col_last) begin
            // Final element: a missing s_last is still flagged, but the load did complete.
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = !io.s_last;
          end else if (io.s_last) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else if (tr_q) begin
            if (row_last) begin
              row_d = '0;
              col_d = col_q + DIM_W'(1);
            end else begin
              row_d = row_q + DIM_W'(1);
            end
          end else begin
            if (col_last) begin
              col_d = '0;
              row_d = row_q + DIM_W'(1);
            end else begin
              col_d = col_q + DIM_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      m_dim_q  <= '0;
      n_dim_q  <= '0;
      wr_m_q   <= '0;
      wr_n_q   <= '0;
      wr_dat_q <= '0;
      tr_q     <= 1'b0;
      wr_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      m_dim_q  <= m_dim_d;
      n_dim_q  <= n_dim_d;
      wr_m_q   <= wr_m_d;
      wr_n_q   <= wr_n_d;
      wr_dat_q <= wr_dat_d;
      tr_q     <= tr_d;
      wr_q     <= wr_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign io.s_ready    = (state_q == LOAD);
  assign busy          = (state_q == LOAD);
  assign io.mem_write  = wr_q;
  assign io.mem_m_addr = wr_m_q;
  assign io.mem_n_addr = wr_n_q;
  assign io.mem_data   = wr_dat_q;
  assign io.mem_m_dim  = m_dim_q;
  assign io.mem_n_dim  = n_dim_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_matrix_stream_writer.sv
// Directed bench for matrix_stream_writer: table of load scenarios plus reset and start-while-busy sequences.
module tb_matrix_stream_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] m_dim, n_dim;
  logic       transpose_in;
  logic       busy, done, err;

  always #5 clk = ~clk;

  matrix_stream_writer_if #(.DATA_W(32), .DIM_W(8)) io ();

  matrix_stream_writer #(.DATA_W(32), .DIM_W(8), .MAX_DIM(128)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .m_dim        (m_dim),
    .n_dim        (n_dim),
`ifdef MATRIX_WR_TRANSPOSE_EN
    .transpose_in (transpose_in),
`endif
    .io           (io.slave),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  typedef struct {
    int m;
    int n;
    bit tr;
    bit gap;
    int last_at;
    int exp_wr;
    int exp_done;
    int exp_err;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int wr_m[$];
  int wr_n[$];
  int wr_d[$];
  int wr_c[$];
  int n_done, n_err, busy_seen, spurious, rdy_on_done, done_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wr_m.delete(); wr_n.delete(); wr_d.delete(); wr_c.delete();
    n_done = 0; n_err = 0; busy_seen = 0; spurious = 0; rdy_on_done = 0; done_cyc = -1;
  endtask

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic tick();
    logic acc;
    acc = io.s_valid && io.s_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (io.mem_write) begin
      wr_m.push_back(int'(io.mem_m_addr));
      wr_n.push_back(int'(io.mem_n_addr));
      wr_d.push_back(int'(io.mem_data));
      wr_c.push_back(cyc);
      if (!acc) spurious++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      if (io.s_ready) rdy_on_done++;
    end
    if (err) n_err++;
    if (busy) busy_seen++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"},   busy, 0);
    check({tag, " done"},   done, 0);
    check({tag, " err"},    err, 0);
    check({tag, " s_ready"}, io.s_ready, 0);
    check({tag, " mem_write"}, io.mem_write, 0);
    check({tag, " m_addr"}, io.mem_m_addr, 0);
    check({tag, " n_addr"}, io.mem_n_addr, 0);
    check({tag, " data"},   io.mem_data, 0);
    check({tag, " m_dim"},  io.mem_m_dim, 0);
    check({tag, " n_dim"},  io.mem_n_dim, 0);
  endtask

  int last_m = 0;
  int last_n = 0;

  task automatic run_vec(input vec_t v, input string tag);
    int  k;
    int  guard;
    bit  ph;
    logic acc_now;
    int  nchk;
    int  em, en;
    k = 1; guard = 0; ph = 1'b0;
    clear_mon();
    m_dim = 8'(v.m); n_dim = 8'(v.n); transpose_in = v.tr; start = 1'b1;
    tick();
    start = 1'b0;
    while (busy && guard < 2000) begin
      io.s_valid = v.gap ? ph : 1'b1;
      ph = !ph;
      io.s_data  = 32'(k);
      io.s_last  = (k == v.last_at);
      acc_now    = io.s_valid && io.s_ready;
      tick();
      if (acc_now) k++;
      guard++;
    end
    io.s_valid = 1'b0;
    io.s_last  = 1'b0;
    check({tag, " no_timeout"}, guard < 2000, 1);
    repeat (3) tick();

    check({tag, " writes"}, wr_m.size(), v.exp_wr);
    nchk = (wr_m.size() < v.exp_wr) ? wr_m.size() : v.exp_wr;
    for (int i = 0; i < nchk; i++) begin
      if (transpose_in) begin
        em = i % v.m; en = i / v.m;
      end else begin
        em = i / v.n; en = i % v.n;
      end
      check($sformatf("%s w%0d m_addr", tag, i), wr_m[i], em);
      check($sformatf("%s w%0d n_addr", tag, i), wr_n[i], en);
      check($sformatf("%s w%0d data", tag, i), wr_d[i], i + 1);
    end
    check({tag, " done_cnt"}, n_done, v.exp_done);
    check({tag, " err_cnt"}, n_err, v.exp_err);
    check({tag, " spurious_wr"}, spurious, 0);
    check({tag, " ready_on_done"}, rdy_on_done, 0);
    if (v.exp_wr == 0) begin
      check({tag, " busy_seen"}, busy_seen, 0);
      check({tag, " dims_kept_m"}, io.mem_m_dim, last_m);
      check({tag, " dims_kept_n"}, io.mem_n_dim, last_n);
    end else begin
      last_m = v.m; last_n = v.n;
      check({tag, " mem_m_dim"}, io.mem_m_dim, v.m);
      check({tag, " mem_n_dim"}, io.mem_n_dim, v.n);
      if (v.exp_done > 0 && wr_c.size() > 0)
        check({tag, " done_with_last_wr"}, done_cyc, wr_c[wr_c.size()-1]);
      if (!v.gap && wr_c.size() == v.exp_wr && v.exp_wr > 1)
        check({tag, " back_to_back"}, wr_c[wr_c.size()-1] - wr_c[0], v.exp_wr - 1);
    end
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{m:2,   n:3,   tr:0, gap:0, last_at:6,   exp_wr:6,   exp_done:1, exp_err:0});
    vecs.push_back('{m:3,   n:3,   tr:0, gap:1, last_at:9,   exp_wr:9,   exp_done:1, exp_err:0});
    vecs.push_back('{m:0,   n:3,   tr:0, gap:0, last_at:0,   exp_wr:0,   exp_done:0, exp_err:1});
    vecs.push_back('{m:129, n:3,   tr:0, gap:0, last_at:0,   exp_wr:0,   exp_done:0, exp_err:1});
    vecs.push_back('{m:2,   n:2,   tr:0, gap:0, last_at:2,   exp_wr:2,   exp_done:0, exp_err:1});
    vecs.push_back('{m:1,   n:1,   tr:0, gap:0, last_at:1,   exp_wr:1,   exp_done:1, exp_err:0});
    vecs.push_back('{m:1,   n:2,   tr:0, gap:0, last_at:0,   exp_wr:2,   exp_done:1, exp_err:1});
    vecs.push_back('{m:128, n:1,   tr:0, gap:0, last_at:128, exp_wr:128, exp_done:1, exp_err:0});
    vecs.push_back('{m:2,   n:129, tr:0, gap:0, last_at:0,   exp_wr:0,   exp_done:0, exp_err:1});
`ifdef MATRIX_WR_TRANSPOSE_EN
    vecs.push_back('{m:2,   n:3,   tr:1, gap:0, last_at:6,   exp_wr:6,   exp_done:1, exp_err:0});
`endif

    reset = 1'b1; start = 1'b0; m_dim = '0; n_dim = '0; transpose_in = 1'b0;
    io.s_valid = 1'b0; io.s_data = '0; io.s_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    clear_mon();
    tick();

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // start while busy must not disturb the running 2x2 load
    clear_mon();
    m_dim = 8'd2; n_dim = 8'd2; transpose_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      io.s_valid = 1'b1; io.s_data = 32'(b); io.s_last = (b == 4);
      if (b == 2) begin
        start = 1'b1; m_dim = 8'd3; n_dim = 8'd3;
      end
      tick();
      start = 1'b0;
    end
    io.s_valid = 1'b0; io.s_last = 1'b0;
    repeat (2) tick();
    check("busy_start writes", wr_m.size(), 4);
    check("busy_start done", n_done, 1);
    check("busy_start err", n_err, 0);
    check("busy_start m_dim", io.mem_m_dim, 2);
    check("busy_start n_dim", io.mem_n_dim, 2);
    if (wr_m.size() == 4) begin
      check("busy_start last m", wr_m[3], 1);
      check("busy_start last n", wr_n[3], 1);
      check("busy_start last d", wr_d[3], 4);
    end

    // reset in the middle of a 4x4 load, then a 1x1 load
    clear_mon();
    m_dim = 8'd4; n_dim = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 1; b <= 3; b++) begin
      io.s_valid = 1'b1; io.s_data = 32'(b); io.s_last = 1'b0;
      tick();
    end
    io.s_valid = 1'b0;
    check("pre_reset writes", wr_m.size(), 3);
    check("pre_reset busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_zero("mid_reset");
    reset = 1'b0;
    clear_mon();
    tick();
    m_dim = 8'd1; n_dim = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("post_reset ready", io.s_ready, 1);
    io.s_valid = 1'b1; io.s_data = 32'd77; io.s_last = 1'b1;
    tick();
    io.s_valid = 1'b0; io.s_last = 1'b0;
    repeat (2) tick();
    check("post_reset writes", wr_m.size(), 1);
    if (wr_m.size() == 1) begin
      check("post_reset m", wr_m[0], 0);
      check("post_reset n", wr_n[0], 0);
      check("post_reset d", wr_d[0], 77);
    end
    check("post_reset done", n_done, 1);
    check("post_reset err", n_err, 0);
    check("post_reset busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
